// File: rtl/instr_feeder_if.sv
// Load-port and core-issue signal bundle for instr_feeder.
//   master : loader/bench side, drives load_valid/load_data/start/stall
//   slave  : feeder side, drives load_ready and the core-facing outputs
//   load_valid/load_data/load_ready : valid/ready instruction push port
//   start/stall                     : run control
//   dataIN/en/RW                    : instruction stream into the core
//   busy/done/count                 : status
interface instr_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_ready;
  logic          start;
  logic          stall;
  logic [31:0]   dataIN;
  logic          en;
  logic          RW;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output load_valid, load_data, start, stall,
    input  load_ready, dataIN, en, RW, busy, done, count
  );

  modport slave (
    input  load_valid, load_data, start, stall,
    output load_ready, dataIN, en, RW, busy, done, count
  );
endinterface

// File: rtl/instr_feeder.sv
// Instruction-stream transmitter for the single-cycle core.
// Buffers 32-bit words from the load port in a DEPTH-entry FIFO, then on
// start issues them one per clock onto dataIN with en/RW asserted.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : instr_feeder_if.slave (load port, run control, core outputs, status)
// All bus outputs are registered except load_ready.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | accept pushes, dataIN=NOP, wait for start
// S_RUN  | issue one word per non-stalled cycle until the FIFO drains
// S_DONE | one-cycle done pulse, then back to S_IDLE
module instr_feeder #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst,
  instr_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   dataIN_q;
  logic          en_q;
  logic          busy_q;
  logic          done_q;

  logic          load_ready;
  logic          push_d;
  logic [CW-1:0] count_d;
  logic [31:0]   head_d;

  assign load_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  assign push_d     = bus.load_valid && load_ready;
  assign count_d    = count_q + CW'(push_d);
  // With an empty FIFO the word being pushed on this edge is the head, so a
  // push coinciding with start can be issued immediately.
  assign head_d     = (count_q == '0) ? bus.load_data : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_d) mem_q[wr_ptr_q] <= bus.load_data;
  end

  // The first word is issued on the edge that samples start, so it shows on
  // dataIN in the first RUN cycle; RUN ends one cycle after the last pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dataIN_q <= NOP;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + AW'(1);
      case (state_q)
        S_IDLE: begin
          dataIN_q <= NOP;
          en_q     <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          count_q  <= count_d;
          if (bus.start) begin
            if (count_d != '0) begin
              state_q  <= S_RUN;
              busy_q   <= 1'b1;
              en_q     <= 1'b1;
              dataIN_q <= head_d;
              rd_ptr_q <= rd_ptr_q + AW'(1);
              count_q  <= count_d - CW'(1);
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (count_q == '0) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            en_q     <= 1'b0;
            dataIN_q <= NOP;
          end else if (bus.stall) begin
            en_q     <= 1'b0;
            dataIN_q <= NOP;
          end else begin
            en_q     <= 1'b1;
            dataIN_q <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_q - CW'(1);
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          done_q   <= 1'b0;
          en_q     <= 1'b0;
          busy_q   <= 1'b0;
          dataIN_q <= NOP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.dataIN     = dataIN_q;
  assign bus.en         = en_q;
  assign bus.RW         = en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_feeder_if #(.DEPTH(DEPTH)) bus ();
  instr_feeder #(.DEPTH(DEPTH), .NOP(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        st;
    logic        sl;
    logic        rdy;
    logic [31:0] d;
    logic        e;
    logic        b;
    logic        dn;
    int          c;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] q[$];
  logic [31:0] expq[$];

  function automatic vec_t mk(logic lv, logic [31:0] ld, logic st, logic sl, logic rdy,
                              logic [31:0] d, logic e, logic b, logic dn, int c);
    vec_t v;
    v.lv = lv; v.ld = ld; v.st = st; v.sl = sl; v.rdy = rdy;
    v.d = d; v.e = e; v.b = b; v.dn = dn; v.c = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input logic [31:0] d, input logic e, input logic b,
                         input logic dn, input int c);
    chk({nm, ".dataIN"}, bus.dataIN, d);
    chk({nm, ".en"},     32'(bus.en), 32'(e));
    chk({nm, ".RW"},     32'(bus.RW), 32'(e));
    chk({nm, ".busy"},   32'(bus.busy), 32'(b));
    chk({nm, ".done"},   32'(bus.done), 32'(dn));
    chk({nm, ".count"},  32'(bus.count), c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.load_valid = 1'b0;
    bus.load_data  = 32'h0;
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_w(input logic [31:0] w);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    tick();
    bus.load_valid = 1'b0;
  endtask

  // Start and expect every word of expq back-to-back, then the done pulse.
  task automatic run_expect(input string nm);
    logic [31:0] w;
    bus.start = 1'b1;
    tick();
    idle_in();
    while (expq.size() > 0) begin
      w = expq.pop_front();
      chk_out({nm, ".issue"}, w, 1'b1, 1'b1, 1'b0, expq.size());
      tick();
    end
    chk_out({nm, ".done"}, NOP, 1'b0, 1'b0, 1'b1, 0);
    tick();
    chk({nm, ".idle_done"}, 32'(bus.done), 32'h0);
    chk({nm, ".idle_ready"}, 32'(bus.load_ready), 32'h1);
  endtask

  initial begin
    logic [31:0] w;
    logic        stalled;
    logic        fin;
    int          npush;

    idle_in();
    rst = 1'b1;
    #12;
    chk_out("reset", NOP, 1'b0, 1'b0, 1'b0, 0);
    chk("reset.ready", 32'(bus.load_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // basic run, stall, empty start, push-with-start
    tbl.push_back(mk(1, 32'h00400093, 0, 0, 1, NOP,          0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h00500113, 0, 0, 1, NOP,          0, 0, 0, 2));
    tbl.push_back(mk(1, 32'h40110233, 0, 0, 1, NOP,          0, 0, 0, 3));
    tbl.push_back(mk(0, 32'h0,        1, 0, 0, 32'h00400093, 1, 1, 0, 2));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 32'h00500113, 1, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 32'h40110233, 1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, NOP,          0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, NOP,          0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h000000A1, 0, 1, 1, NOP,          0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h000000A2, 0, 0, 1, NOP,          0, 0, 0, 2));
    tbl.push_back(mk(1, 32'h000000A3, 0, 0, 1, NOP,          0, 0, 0, 3));
    tbl.push_back(mk(0, 32'h0,        1, 0, 0, 32'h000000A1, 1, 1, 0, 2));
    tbl.push_back(mk(0, 32'h0,        0, 1, 0, NOP,          0, 1, 0, 2));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 32'h000000A2, 1, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 32'h000000A3, 1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 0, NOP,          0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, NOP,          0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 0, NOP,          0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, NOP,          0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h000000B1, 1, 0, 0, 32'h000000B1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, NOP,          0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 1, NOP,          0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      bus.load_valid = tbl[i].lv;
      bus.load_data  = tbl[i].ld;
      bus.start      = tbl[i].st;
      bus.stall      = tbl[i].sl;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].d, tbl[i].e, tbl[i].b, tbl[i].dn, tbl[i].c);
      chk($sformatf("vec%0d.ready", i), 32'(bus.load_ready), 32'(tbl[i].rdy));
    end
    idle_in();

    // randomized load/run rounds against a FIFO-queue reference
    for (int r = 0; r < 25; r++) begin
      npush = $urandom_range(0, DEPTH + 2);
      for (int k = 0; k < npush; k++) begin
        bus.load_valid = ($urandom_range(0, 3) != 0);
        bus.load_data  = $urandom;
        bus.stall      = 1'($urandom_range(0, 1));
        chk("rnd.ready", 32'(bus.load_ready), 32'(q.size() < DEPTH));
        if (bus.load_valid && q.size() < DEPTH) q.push_back(bus.load_data);
        tick();
        chk("rnd.count", 32'(bus.count), q.size());
        chk("rnd.idle_en", 32'(bus.en), 32'h0);
      end
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.load_data  = $urandom;
      bus.start      = 1'b1;
      bus.stall      = 1'($urandom_range(0, 1));
      if (bus.load_valid && q.size() < DEPTH) q.push_back(bus.load_data);
      tick();
      idle_in();
      if (q.size() == 0) begin
        chk_out("rnd.empty", NOP, 1'b0, 1'b0, 1'b1, 0);
      end else begin
        w = q.pop_front();
        chk_out("rnd.first", w, 1'b1, 1'b1, 1'b0, q.size());
        fin = 1'b0;
        for (int cyc = 0; cyc < 6 * DEPTH && !fin; cyc++) begin
          bus.stall      = ($urandom_range(0, 2) == 0);
          bus.start      = 1'($urandom_range(0, 1));
          bus.load_valid = 1'($urandom_range(0, 1));
          bus.load_data  = $urandom;
          chk("rnd.ready_run", 32'(bus.load_ready), 32'h0);
          stalled = bus.stall;
          tick();
          if (q.size() == 0) begin
            chk_out("rnd.done", NOP, 1'b0, 1'b0, 1'b1, 0);
            fin = 1'b1;
          end else if (stalled) begin
            chk_out("rnd.stall", NOP, 1'b0, 1'b1, 1'b0, q.size());
          end else begin
            w = q.pop_front();
            chk_out("rnd.issue", w, 1'b1, 1'b1, 1'b0, q.size());
          end
        end
        chk("rnd.done_reached", 32'(fin), 32'h1);
        q.delete();
      end
      idle_in();
      tick();
      chk("rnd.back_done", 32'(bus.done), 32'h0);
      chk("rnd.back_ready", 32'(bus.load_ready), 32'h1);
    end

    // overflow: ninth word dropped
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 32'(i);
      chk("ovf.ready", 32'(bus.load_ready), 32'(i <= DEPTH));
      tick();
      chk("ovf.count", 32'(bus.count), (i <= DEPTH) ? i : DEPTH);
    end
    idle_in();
    for (int i = 1; i <= DEPTH; i++) expq.push_back(32'(i));
    run_expect("ovf");

    // reset in the middle of a run
    for (int i = 0; i < 4; i++) push_w(32'h50 + 32'(i));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rst.issue0", bus.dataIN, 32'h50);
    tick();
    chk("rst.issue1", bus.dataIN, 32'h51);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst.mid", NOP, 1'b0, 1'b0, 1'b0, 0);
    chk("rst.ready", 32'(bus.load_ready), 32'h1);
    rst = 1'b0;
    push_w(32'h60);
    push_w(32'h61);
    chk("rst.reload_count", 32'(bus.count), 32'h2);
    expq.push_back(32'h60);
    expq.push_back(32'h61);
    run_expect("rst.rerun");

    // pointer wrap across two runs
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_w(32'h70 + 32'(i));
      expq.push_back(32'h70 + 32'(i));
    end
    run_expect("wrap.a");
    for (int i = 0; i < 6; i++) begin
      push_w(32'h80 + 32'(i));
      expq.push_back(32'h80 + 32'(i));
    end
    run_expect("wrap.b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
